tcm_dport_arb: RTL and testbench
================================

TCM_DPORT_ARB -- requirements
Module: tcm_dport_arb

Interface
REQ-001 Parameters (name, default, meaning):
- DEPTH, 4, maximum outstanding accepted-but-unacknowledged requests (power of 2, >=2).
REQ-002 Ports (name, direction, width, meaning):
- clk_i  in  1  single clock
- rst_ni  in  1  asynchronous active-low reset
- mN_rd_i  in  1  requester N read (N=0 core data, N=1 external loader)
- mN_wr_i  in  4  requester N byte-write strobes
- mN_addr_i  in  32  requester N byte address
- mN_data_wr_i  in  32  requester N write data
- mN_tag_i  in  11  requester N request tag
- mN_accept_o  out  1  requester N request taken this cycle
- mN_ack_o  out  1  requester N response valid
- mN_data_rd_o  out  32  requester N read data
- mN_resp_tag_o  out  11  requester N response tag
- mem_rd_o / mem_wr_o / mem_addr_o / mem_data_wr_o / mem_tag_o  out  1/4/32/32/11  granted request to TCM data port
- mem_accept_i  in  1  TCM takes request
- mem_ack_i  in  1  TCM response valid (in order, >=1 cycle after accept)
- mem_data_rd_i  in  32  TCM read data
- mem_resp_tag_i  in  11  TCM response tag
- outstanding_o  out  log2(DEPTH)+1  outstanding request count
- err_o  out  1  sticky: ack received with no outstanding request

Function
REQ-003 Request from N is pending when mN_rd_i=1 or mN_wr_i!=0.
REQ-004 Arbitration: round-robin, 1-bit priority pointer; if only one requester is pending it is granted; if both are pending, the pointer's requester is granted.
REQ-005 Grant is combinational; mem_* outputs mirror the granted requester's fields; with no grant, mem_rd_o=0 and mem_wr_o=0.
REQ-006 Handshake: mN_accept_o=1 only when N is granted, mem_accept_i=1 and the FIFO is not full; the request is transferred in the same cycle.
REQ-007 FIFO full blocks all grants: mem_rd_o=0, mem_wr_o=0 and both accepts=0, including in a cycle where mem_ack_i pops.
REQ-008 On a transferred request the pointer moves to the non-granted requester; otherwise it holds.
REQ-009 Response routing: a DEPTH-entry in-order FIFO stores the requester ID; push on transfer, pop on mem_ack_i.
REQ-010 mN_ack_o = mem_ack_i when FIFO head ID=N and the FIFO is non-empty; mN_data_rd_o = mem_data_rd_i; mN_resp_tag_o = mem_resp_tag_i (both broadcast).
REQ-011 Simultaneous push and pop with the FIFO not full: count unchanged, both pointers advance, and they wrap modulo DEPTH.
REQ-012 mem_ack_i with the FIFO empty: dropped, no ack is driven, count stays 0, and err_o sets and stays set until reset.
REQ-013 outstanding_o = FIFO occupancy, in the range 0..DEPTH.
REQ-014 Latency: request path 0 cycles (combinational); response path 0 cycles from mem_ack_i.

Reset
REQ-015 rst_ni low asynchronously clears FIFO pointers, count, pointer (to requester 0) and err_o; all acks and accepts are 0 and mem_rd_o/mem_wr_o are 0 while reset is asserted.
REQ-016 Reset mid-operation discards outstanding IDs; acks arriving after reset release are handled per REQ-012.

Structure
REQ-017 Shared package tcm_arb_pkg holds TAG_W=11, the requester ID typedef and the request-bundle struct.
REQ-018 Sub-module tcm_arb_fifo is the ID FIFO (push, pop, full, empty, count, head).

Verification
REQ-019 Both requesters issue a continuous read, mem_accept_i=1, ack 1 cycle later -> grants alternate 0,1,0,1 and each ack is routed to the issuer with its tag.
REQ-020 DEPTH=4, mem_ack_i held 0, m0 reads continuously -> 4 accepts, outstanding_o=4, 5th request is blocked even with an ack in the same cycle.
REQ-021 m1 writes wr=4'hF, addr=0x100, data=0xDEADBEEF, then m0 reads 0x100 -> m0_data_rd_o=0xDEADBEEF, m0_ack_o=1 and m1_ack_o=0.
REQ-022 mem_ack_i pulse with the FIFO empty -> no mN_ack_o, err_o=1 and held until reset.
REQ-023 Three outstanding requests, then rst_ni asserted asynchronously mid-cycle -> outstanding_o=0 and all outputs are 0 immediately.
REQ-024 mem_accept_i=0 for 3 cycles with both requesting -> no accepts and the pointer is unchanged; the first accept goes to the pointer's requester.

Source files
------------

// File: rtl/tcm_arb_pkg.sv
// Shared types for the TCM data-port arbiter: tag width, requester ID and
// the request bundle that is muxed onto the memory port.
package tcm_arb_pkg;

  localparam int unsigned TAG_W = 11;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_LOAD = 1'b1
  } req_id_t;

  typedef struct packed {
    logic             rd;
    logic [3:0]       wr;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } req_t;

  function automatic logic req_pending(input req_t r);
    return r.rd | (|r.wr);
  endfunction

endpackage

// File: rtl/tcm_arb_fifo.sv
// In-order FIFO of requester IDs for outstanding memory requests; the head
// entry selects which requester receives the next memory response.
module tcm_arb_fifo
  import tcm_arb_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  req_id_t push_id,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output logic [AW:0] count,
  output req_id_t head
);

  req_id_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/tcm_dport_arb.sv
// Two-requester round-robin arbiter for the TCM data port with in-order
// response routing back to the requester that issued each request.
module tcm_dport_arb
  import tcm_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,

  input  logic                     m0_rd_i,
  input  logic [3:0]               m0_wr_i,
  input  logic [31:0]              m0_addr_i,
  input  logic [31:0]              m0_data_wr_i,
  input  logic [TAG_W-1:0]         m0_tag_i,
  output logic                     m0_accept_o,
  output logic                     m0_ack_o,
  output logic [31:0]              m0_data_rd_o,
  output logic [TAG_W-1:0]         m0_resp_tag_o,

  input  logic                     m1_rd_i,
  input  logic [3:0]               m1_wr_i,
  input  logic [31:0]              m1_addr_i,
  input  logic [31:0]              m1_data_wr_i,
  input  logic [TAG_W-1:0]         m1_tag_i,
  output logic                     m1_accept_o,
  output logic                     m1_ack_o,
  output logic [31:0]              m1_data_rd_o,
  output logic [TAG_W-1:0]         m1_resp_tag_o,

  output logic                     mem_rd_o,
  output logic [3:0]               mem_wr_o,
  output logic [31:0]              mem_addr_o,
  output logic [31:0]              mem_data_wr_o,
  output logic [TAG_W-1:0]         mem_tag_o,
  input  logic                     mem_accept_i,
  input  logic                     mem_ack_i,
  input  logic [31:0]              mem_data_rd_i,
  input  logic [TAG_W-1:0]         mem_resp_tag_i,

  output logic [$clog2(DEPTH):0]   outstanding_o,
  output logic                     err_o
);

  req_t    req0;
  req_t    req1;
  req_t    gnt_req;
  req_t    mem_req;
  logic    pend0;
  logic    pend1;
  logic    gnt_valid;
  req_id_t gnt_id;
  req_id_t prio;
  logic    transfer;
  logic    fifo_full;
  logic    fifo_empty;
  logic    pop;
  req_id_t head_id;

  always_comb begin
    req0 = '{rd: m0_rd_i, wr: m0_wr_i, addr: m0_addr_i, data: m0_data_wr_i, tag: m0_tag_i};
    req1 = '{rd: m1_rd_i, wr: m1_wr_i, addr: m1_addr_i, data: m1_data_wr_i, tag: m1_tag_i};
    pend0 = req_pending(req0);
    pend1 = req_pending(req1);

    // A full FIFO blocks every grant, even when an ack frees a slot this cycle.
    gnt_valid = rst_ni & ~fifo_full & (pend0 | pend1);
    if (pend0 && pend1) gnt_id = prio;
    else if (pend1)     gnt_id = REQ_LOAD;
    else                gnt_id = REQ_CORE;

    gnt_req  = (gnt_id == REQ_LOAD) ? req1 : req0;
    mem_req  = gnt_valid ? gnt_req : '0;
    transfer = gnt_valid & mem_accept_i;
  end

  assign mem_rd_o      = mem_req.rd;
  assign mem_wr_o      = mem_req.wr;
  assign mem_addr_o    = mem_req.addr;
  assign mem_data_wr_o = mem_req.data;
  assign mem_tag_o     = mem_req.tag;

  assign m0_accept_o = transfer & (gnt_id == REQ_CORE);
  assign m1_accept_o = transfer & (gnt_id == REQ_LOAD);

  assign pop      = mem_ack_i & ~fifo_empty;
  assign m0_ack_o = pop & (head_id == REQ_CORE);
  assign m1_ack_o = pop & (head_id == REQ_LOAD);

  assign m0_data_rd_o  = mem_data_rd_i;
  assign m1_data_rd_o  = mem_data_rd_i;
  assign m0_resp_tag_o = mem_resp_tag_i;
  assign m1_resp_tag_o = mem_resp_tag_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio  <= REQ_CORE;
      err_o <= 1'b0;
    end else begin
      if (transfer) prio <= (gnt_id == REQ_CORE) ? REQ_LOAD : REQ_CORE;
      if (mem_ack_i && fifo_empty) err_o <= 1'b1;
    end
  end

  tcm_arb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .push    (transfer),
    .push_id (gnt_id),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (outstanding_o),
    .head    (head_id)
  );

endmodule

// File: tb/tb_tcm_dport_arb.sv
// Directed bench for tcm_dport_arb: a cycle table for arbitration/routing
// plus hand sequences for round-robin, FIFO-full, error and reset cases.
module tb_tcm_dport_arb;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        m0_rd, m1_rd;
  logic [3:0]  m0_wr, m1_wr;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [10:0] m0_tag, m1_tag;
  logic        m0_accept, m1_accept, m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [10:0] m0_rtag, m1_rtag;
  logic        mem_rd;
  logic [3:0]  mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [10:0] mem_tag;
  logic        mem_accept, mem_ack;
  logic [31:0] mem_rdata;
  logic [10:0] mem_rtag;
  logic [2:0]  outstanding;
  logic        err;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  tcm_dport_arb #(.DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m0_rd_i(m0_rd), .m0_wr_i(m0_wr), .m0_addr_i(m0_addr), .m0_data_wr_i(m0_wdata),
    .m0_tag_i(m0_tag), .m0_accept_o(m0_accept), .m0_ack_o(m0_ack),
    .m0_data_rd_o(m0_rdata), .m0_resp_tag_o(m0_rtag),
    .m1_rd_i(m1_rd), .m1_wr_i(m1_wr), .m1_addr_i(m1_addr), .m1_data_wr_i(m1_wdata),
    .m1_tag_i(m1_tag), .m1_accept_o(m1_accept), .m1_ack_o(m1_ack),
    .m1_data_rd_o(m1_rdata), .m1_resp_tag_o(m1_rtag),
    .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr), .mem_data_wr_o(mem_wdata),
    .mem_tag_o(mem_tag), .mem_accept_i(mem_accept), .mem_ack_i(mem_ack),
    .mem_data_rd_i(mem_rdata), .mem_resp_tag_i(mem_rtag),
    .outstanding_o(outstanding), .err_o(err)
  );

  typedef struct {
    logic       m0_rd;
    logic [3:0] m0_wr;
    logic       m1_rd;
    logic [3:0] m1_wr;
    logic       macc;
    logic       mack;
    logic [1:0] e_acc;   // {m1, m0}
    logic [1:0] e_ack;   // {m1, m0}
    logic       e_mrd;
    logic [3:0] e_mwr;
    logic [2:0] e_out;
    logic       e_gnt;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_rd = 0; m0_wr = '0; m1_rd = 0; m1_wr = '0;
    m0_addr = 32'h1000; m0_wdata = 32'hA0A0_A0A0; m0_tag = 11'h155;
    m1_addr = 32'h2000; m1_wdata = 32'h5B5B_5B5B; m1_tag = 11'h2AA;
    mem_accept = 0; mem_ack = 0; mem_rdata = '0; mem_rtag = '0;
  endtask

  task automatic do_reset();
    rst_ni = 0;
    idle_inputs();
    #3;
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_outs", {m1_accept, m0_accept, m1_ack, m0_ack, mem_rd, mem_wr}, '0);
    step();
    rst_ni = 1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // m0_rd m0_wr m1_rd m1_wr acc ack | e_acc e_ack mrd mwr out gnt
    vecs[0] = '{0, 4'h0, 0, 4'h0, 1, 0, 2'b00, 2'b00, 0, 4'h0, 3'd0, 0};
    vecs[1] = '{1, 4'h0, 1, 4'h0, 1, 0, 2'b01, 2'b00, 1, 4'h0, 3'd0, 0};
    vecs[2] = '{1, 4'h0, 1, 4'h0, 1, 1, 2'b10, 2'b01, 1, 4'h0, 3'd1, 1};
    vecs[3] = '{0, 4'h0, 0, 4'hF, 1, 0, 2'b10, 2'b00, 0, 4'hF, 3'd1, 1};
    vecs[4] = '{1, 4'h0, 1, 4'h0, 0, 1, 2'b00, 2'b10, 1, 4'h0, 3'd2, 0};
    vecs[5] = '{0, 4'h3, 0, 4'h0, 1, 1, 2'b01, 2'b10, 0, 4'h3, 3'd1, 0};
    vecs[6] = '{0, 4'h0, 0, 4'h0, 0, 1, 2'b00, 2'b01, 0, 4'h0, 3'd1, 0};
    vecs[7] = '{0, 4'h0, 0, 4'h0, 1, 0, 2'b00, 2'b00, 0, 4'h0, 3'd0, 0};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      m0_rd = vecs[i].m0_rd; m0_wr = vecs[i].m0_wr;
      m1_rd = vecs[i].m1_rd; m1_wr = vecs[i].m1_wr;
      mem_accept = vecs[i].macc; mem_ack = vecs[i].mack;
      #1;
      chk($sformatf("v%0d_accept", i), {m1_accept, m0_accept}, vecs[i].e_acc);
      chk($sformatf("v%0d_ack", i), {m1_ack, m0_ack}, vecs[i].e_ack);
      chk($sformatf("v%0d_mem_rdwr", i), {mem_rd, mem_wr}, {vecs[i].e_mrd, vecs[i].e_mwr});
      chk($sformatf("v%0d_outstanding", i), 64'(outstanding), 64'(vecs[i].e_out));
      if (vecs[i].e_mrd || vecs[i].e_mwr != 0)
        chk($sformatf("v%0d_mem_addr_tag", i), {mem_addr, mem_tag},
            vecs[i].e_gnt ? {32'h2000, 11'h2AA} : {32'h1000, 11'h155});
      step();
    end
    chk("table_err", 64'(err), 64'd0);

    // Continuous reads from both, 1-cycle ack latency: grants alternate.
    do_reset();
    m0_rd = 1; m1_rd = 1; mem_accept = 1;
    for (int k = 0; k < 8; k++) begin
      mem_ack   = (k > 0);
      mem_rtag  = (k % 2 == 1) ? 11'h155 : 11'h2AA;
      mem_rdata = 32'(k);
      #1;
      chk($sformatf("rr%0d_accept", k), {m1_accept, m0_accept}, (k % 2) ? 2'b10 : 2'b01);
      if (k > 0) begin
        chk($sformatf("rr%0d_ack", k), {m1_ack, m0_ack}, (k % 2) ? 2'b01 : 2'b10);
        chk($sformatf("rr%0d_rtag", k), (k % 2) ? 64'(m0_rtag) : 64'(m1_rtag),
            (k % 2) ? 64'h155 : 64'h2AA);
      end
      step();
    end

    // FIFO full: four accepts, then blocked even with an ack popping.
    do_reset();
    m0_rd = 1; mem_accept = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("full_acc%0d", k), 64'(m0_accept), 64'd1);
      step();
    end
    chk("full_outstanding", 64'(outstanding), 64'd4);
    mem_ack = 1;
    #1;
    chk("full_blocked", {m1_accept, m0_accept, mem_rd, mem_wr}, '0);
    chk("full_pop_ack", {m1_ack, m0_ack}, 2'b01);
    step();
    mem_ack = 0;
    chk("full_after_pop", 64'(outstanding), 64'd3);
    #1;
    chk("full_resume_acc", 64'(m0_accept), 64'd1);
    step();

    // Write from m1 then read back through m0.
    do_reset();
    m1_wr = 4'hF; m1_addr = 32'h100; m1_wdata = 32'hDEAD_BEEF; mem_accept = 1;
    #1;
    chk("wr_fields", {m1_accept, mem_wr, mem_addr, mem_wdata}, {1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF});
    step();
    m1_wr = '0; m0_rd = 1; m0_addr = 32'h100; mem_ack = 1;
    #1;
    chk("rd_issue", {m0_accept, mem_rd, mem_addr}, {1'b1, 1'b1, 32'h100});
    chk("wr_ack", {m1_ack, m0_ack}, 2'b10);
    step();
    m0_rd = 0; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_ack", {m1_ack, m0_ack}, 2'b01);
    chk("rd_data", 64'(m0_rdata), 64'hDEAD_BEEF);
    step();
    mem_ack = 0;

    // Ack with nothing outstanding: dropped and error sticks.
    do_reset();
    mem_ack = 1;
    #1;
    chk("empty_ack_drop", {m1_ack, m0_ack}, 2'b00);
    step();
    mem_ack = 0;
    chk("err_set", 64'(err), 64'd1);
    chk("err_cnt", 64'(outstanding), 64'd0);
    repeat (3) step();
    chk("err_held", 64'(err), 64'd1);

    // Asynchronous reset mid-cycle with three outstanding.
    do_reset();
    chk("err_cleared", 64'(err), 64'd0);
    m0_rd = 1; mem_accept = 1;
    repeat (3) step();
    chk("pre_rst_outstanding", 64'(outstanding), 64'd3);
    mem_ack = 1;
    #1;
    rst_ni = 0;
    #1;
    chk("async_rst_outstanding", 64'(outstanding), 64'd0);
    chk("async_rst_outs", {m1_accept, m0_accept, m1_ack, m0_ack, mem_rd, mem_wr, err}, '0);
    m0_rd = 0;
    #1;
    rst_ni = 1;
    #1;
    chk("post_rst_ack_drop", {m1_ack, m0_ack}, 2'b00);
    step();
    chk("post_rst_err", 64'(err), 64'd1);
    mem_ack = 0;

    // Stalled memory: pointer holds, first accept goes to pointer's requester.
    do_reset();
    m0_rd = 1; mem_accept = 1;
    step();
    m1_rd = 1; mem_accept = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_acc", k), {m1_accept, m0_accept}, 2'b00);
      step();
    end
    mem_accept = 1;
    #1;
    chk("stall_first_acc", {m1_accept, m0_accept}, 2'b10);
    step();
    idle_inputs();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
